operand_fetch: RTL and testbench
================================

# operand_fetch

Register-read stage of the little-cpu pipeline, sitting between decode and execute. It drives the `regfile` read and write ports and absorbs that block's one-cycle registered read latency. It bypasses writeback data that the regfile would return stale, and tracks outstanding writers in a scoreboard. An instruction is released to execute only when both source operands are architecturally current.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `PAYLOAD_W`, 64: opaque decoded-instruction payload (pc, opcode fields) carried alongside the operands.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous kill of the instruction held in this stage.
- `in_valid` in 1, `in_ready` out 1: decode handshake.
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each: register addresses.
- `in_rd_wen`  in  1: instruction writes `in_rd`.
- `in_payload`  in  PAYLOAD_W: decoded-instruction payload.
- `rf_rs1`, `rf_rs2`  out  5: regfile read addresses.
- `rf_reg_rs1`, `rf_reg_rs2`  in  XLEN: regfile read data, valid the cycle after the address is sampled.
- `rf_wen` out 1, `rf_waddr` out 5, `rf_wdata` out XLEN: regfile write port.
- `wb_valid` in 1, `wb_rd` in 5, `wb_data` in XLEN: writeback from the end of the pipeline.
- `out_valid` out 1, `out_ready` in 1: execute handshake.
- `out_rs1_val`, `out_rs2_val`  out  XLEN: resolved operands.
- `out_rd` out 5, `out_rd_wen` out 1, `out_payload` out PAYLOAD_W: registered copies of the accepted instruction.

## Operation
- **Pass-through wiring (combinational):**
  - `rf_rs1 = in_rs1`, `rf_rs2 = in_rs2`.
  - `rf_wen = wb_valid`, `rf_waddr = wb_rd`, `rf_wdata = wb_data`.
- **FSM states:** IDLE, READ, HOLD.
  - `accept = in_valid && in_ready`.
  - `fire = out_valid && out_ready`.
  - `in_ready = !flush && (IDLE || (HOLD && fire))`.
  - IDLE → READ on accept.
  - READ → HOLD unconditionally.
  - HOLD → READ on fire and accept; HOLD → IDLE on fire alone; otherwise stay in HOLD.
  - `flush` forces the next state to IDLE and overrides every other transition.
- **Operand latch and ready flag:** each source n has `opn` (XLEN) and `rdyn`.
  - Register x0 is always ready with value 0.
- **Scoreboard:** `busy[31:1]`.
  - Set `busy[out_rd]` on fire when `out_rd_wen` is high and `out_rd != 0`.
  - Clear `busy[wb_rd]` on `wb_valid`.
  - Set and clear of the same register in one cycle: set wins.
- **Ready flag at accept:** `rdyn` = 0 if rsn ≠ 0 and either of these holds:
  - `busy[rsn]` is set and no `wb_valid` with `wb_rd == rsn` occurs that cycle; or
  - a fire in the same cycle writes rsn. An outgoing writer outranks a same-cycle writeback.
- **Bypass:** any `wb_valid` with `wb_rd == rsn` (rsn ≠ 0) from the accept edge onward, in any of the accept cycle, READ or HOLD:
  - loads `opn ← wb_data` and sets `rdyn`;
  - if it happens in the accept cycle, sets a sticky `bypn` flag.
- **End of READ:** `opn ← rf_reg_rsn` unless `bypn` is set or a matching writeback occurs that cycle.
- **Output valid:** `out_valid = HOLD && rdy1 && rdy2 && !flush`. All `out_*` fields hold stable while `out_valid` is high and `out_ready` is low.
- **Effect of `flush`:**
  - Drops the held instruction and suppresses both fire and accept that cycle.
  - Leaves the scoreboard untouched, since already-issued writers still write back.

## Timing
- **Reset state:**
  - state IDLE, `busy` all 0, all operand and `out_*` registers 0, `rdyn`/`bypn` 0.
  - `out_valid` 0; `in_ready` 1 (when `flush` is low).
- **Latency:** accept at edge N → READ during cycle N+1 → `out_valid` can rise in cycle N+2.
- **Throughput:** one instruction per 2 cycles maximum.
- **Hazard stall:** the instruction waits in HOLD until the matching writeback. `out_valid` rises the cycle after the `wb_valid` edge.
- **Reset mid-operation:** the in-flight instruction is discarded immediately, regardless of clock.

## Structure
- **Package `cpu_pkg`:**
  - `XLEN`, `REG_ADDR_W = 5`;
  - the `of_state_t` enum {IDLE, READ, HOLD}.
- **Sub-module `scoreboard`:**
  - ports: set (enable, addr), clear (enable, addr), two combinational lookup ports;
  - set-wins priority.

## Test plan
- **Simple issue:** reset, with x5 = 7 in the regfile; accept `rs1=5 rs2=0`. Required: `out_valid` in cycle N+2, `out_rs1_val=7`, `out_rs2_val=0`.
- **Accept-cycle bypass:** accept `rs1=3` while `wb_valid wb_rd=3 wb_data=0xAA`. Required: `out_rs1_val=0xAA`, not the stale regfile value.
- **RAW stall:** fire an instruction with `rd=4 rd_wen=1`, then accept one with `rs2=4`. Required:
  - `out_valid` stays low through 5 idle cycles;
  - after `wb_rd=4 wb_data=0x1234`, `out_valid` rises the next cycle with `out_rs2_val=0x1234`.
- **x0 handling:** an instruction with `rd=0 rd_wen=1` fires, followed by `rs1=0`. Required: no stall, operand 0, `busy` unchanged.
- **Backpressure and flush:** hold `out_ready` low for 3 cycles. Required: `out_*` stable. Then pulse `flush`. Required: `out_valid` low immediately, state IDLE, `busy` unchanged.
- **Same-cycle set and clear:** in one cycle, fire with `rd=6` while `wb_rd=6`. Required: `busy[6]` remains set.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the little-cpu pipeline.
//   XLEN       : architectural data width
//   REG_ADDR_W : register address width (32 architectural registers)
//   of_state_t : operand-fetch stage states
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } of_state_t;

endpackage

// File: rtl/scoreboard.sv
// Outstanding-writer scoreboard: one busy bit per register x1..x31.
//   clk, reset            : clock, asynchronous active-high reset
//   set_en, set_addr      : mark a register as having a writer in flight
//   clr_en, clr_addr      : writeback retires the writer of a register
//   lookup_a/b_addr/busy  : combinational lookups (x0 always reads not-busy)
// When set and clear target the same register in one cycle the set wins,
// because the newly issued writer is younger than the one retiring.
module scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t lookup_a_addr,
  output logic      lookup_a_busy,
  input  reg_addr_t lookup_b_addr,
  output logic      lookup_b_busy
);

  logic [NUM_REGS-1:1] busy;
  logic [NUM_REGS-1:0] busy_all;

  // Bit 0 is a constant zero so x0 never reports a pending writer.
  assign busy_all      = {busy, 1'b0};
  assign lookup_a_busy = busy_all[lookup_a_addr];
  assign lookup_b_busy = busy_all[lookup_b_addr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && (set_addr == REG_ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (clr_en && (clr_addr == REG_ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute.
//   clk, reset, flush                  : clock, async active-high reset, sync kill
//   in_valid/in_ready, in_rs1/rs2/rd,
//   in_rd_wen, in_payload              : decode handshake and instruction
//   rf_rs1/rf_rs2, rf_reg_rs1/rs2      : regfile read port (1-cycle registered data)
//   rf_wen/rf_waddr/rf_wdata           : regfile write port (driven from writeback)
//   wb_valid/wb_rd/wb_data             : writeback from the end of the pipeline
//   out_valid/out_ready, out_rs1_val,
//   out_rs2_val, out_rd, out_rd_wen,
//   out_payload                        : execute handshake and resolved instruction
// An instruction is accepted, spends one cycle in READ waiting for regfile
// data, then waits in HOLD until both operands are current.
module operand_fetch #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs1,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rs2,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] in_rd,
  input  logic                          in_rd_wen,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rf_rs1,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]               rf_reg_rs1,
  input  logic [XLEN-1:0]               rf_reg_rs2,
  output logic                          rf_wen,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  input  logic                          wb_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]               wb_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_rs1_val,
  output logic [XLEN-1:0]               out_rs2_val,
  output logic [cpu_pkg::REG_ADDR_W-1:0] out_rd,
  output logic                          out_rd_wen,
  output logic [PAYLOAD_W-1:0]          out_payload
);

  import cpu_pkg::*;

  of_state_t state, state_nxt;
  logic      accept, fire, sb_set;

  // Index 0 is source 1, index 1 is source 2.
  logic [1:0][REG_ADDR_W-1:0] in_rs, rs_q;
  logic [1:0][XLEN-1:0]       op, rf_data;
  logic [1:0]                 rdy, byp, src_busy;
  logic [1:0]                 hit_in, fire_hit, rdy_in, hit_q;

  assign rf_rs1   = in_rs1;
  assign rf_rs2   = in_rs2;
  assign rf_wen   = wb_valid;
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_data;

  assign in_rs   = {in_rs2, in_rs1};
  assign rf_data = {rf_reg_rs2, rf_reg_rs1};

  assign out_valid   = (state == HOLD) && rdy[0] && rdy[1] && !flush;
  assign fire        = out_valid && out_ready;
  assign in_ready    = !flush && ((state == IDLE) || ((state == HOLD) && fire));
  assign accept      = in_valid && in_ready;
  assign sb_set      = fire && out_rd_wen && (out_rd != '0);
  assign out_rs1_val = op[0];
  assign out_rs2_val = op[1];

  scoreboard u_sb (
    .clk           (clk),
    .reset         (reset),
    .set_en        (sb_set),
    .set_addr      (out_rd),
    .clr_en        (wb_valid),
    .clr_addr      (wb_rd),
    .lookup_a_addr (in_rs1),
    .lookup_a_busy (src_busy[0]),
    .lookup_b_addr (in_rs2),
    .lookup_b_busy (src_busy[1])
  );

  // hit_in   : writeback to a source in the accept cycle (regfile would be stale)
  // fire_hit : the instruction leaving now writes that source; it outranks any
  //            same-cycle writeback, which belongs to an older writer
  // hit_q    : writeback to a held source while in READ or HOLD
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      hit_in[n]   = wb_valid && (wb_rd == in_rs[n]) && (in_rs[n] != '0);
      fire_hit[n] = fire && out_rd_wen && (out_rd == in_rs[n]) && (in_rs[n] != '0);
      rdy_in[n]   = (in_rs[n] == '0) ||
                    !((src_busy[n] && !hit_in[n]) || fire_hit[n]);
      hit_q[n]    = wb_valid && (wb_rd == rs_q[n]) && (rs_q[n] != '0);
    end
  end

  // NOTE: next-state logic assigns its default first, so no path leaves
  // state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (fire) state_nxt = accept ? READ : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_payload <= '0;
      rs_q        <= '0;
      op          <= '0;
      rdy         <= '0;
      byp         <= '0;
    end else begin
      if (accept) begin
        out_rd      <= in_rd;
        out_rd_wen  <= in_rd_wen;
        out_payload <= in_payload;
      end
      for (int n = 0; n < 2; n++) begin
        if (accept) begin
          rs_q[n] <= in_rs[n];
          rdy[n]  <= rdy_in[n];
          byp[n]  <= hit_in[n] && !fire_hit[n];
          op[n]   <= (hit_in[n] && !fire_hit[n]) ? wb_data : '0;
        end else if (state != IDLE) begin
          if (hit_q[n]) begin
            op[n]  <= wb_data;
            rdy[n] <= 1'b1;
          end else if ((state == READ) && !byp[n] && (rs_q[n] != '0)) begin
            // Regfile data for the address sampled at the accept edge.
            op[n] <= rf_data[n];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural one-cycle regfile.
module tb_operand_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rd_wen = 1'b0;
  logic [63:0] in_payload = '0;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_reg_rs1 = '0, rf_reg_rs2 = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [63:0] out_payload;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] regs [32];
  logic [31:1] exp_busy;

  operand_fetch #(.XLEN(32), .PAYLOAD_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_payload(in_payload),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_reg_rs1(rf_reg_rs1), .rf_reg_rs2(rf_reg_rs2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_payload(out_payload)
  );

  always #5 clk = ~clk;

  // Regfile: write and registered read on the same edge, read returns old data.
  always @(posedge clk) begin
    if (rf_wen && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
    rf_reg_rs1 <= regs[rf_rs1];
    rf_reg_rs2 <= regs[rf_rs2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic wen,
                          input logic [63:0] pl);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rd_wen = wen; in_payload = pl;
  endtask

  task automatic test_reset();
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset.out_valid got %0b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset.in_ready got %0b want 1", in_ready); end
    vectors++; if (out_rs1_val !== 32'd0 || out_rs2_val !== 32'd0) begin miscompares++; $display("FAIL reset.operands got %h %h want 0 0", out_rs1_val, out_rs2_val); end
    vectors++; if (out_payload !== 64'd0 || out_rd !== 5'd0 || out_rd_wen !== 1'b0) begin miscompares++; $display("FAIL reset.out_fields got %h %0d %0b want 0", out_payload, out_rd, out_rd_wen); end
    vectors++; if (dut.u_sb.busy !== 31'd0) begin miscompares++; $display("FAIL reset.busy got %h want 0", dut.u_sb.busy); end
  endtask

  task automatic test_simple_issue();
    tick();
    drive_in(5'd5, 5'd0, 5'd1, 1'b0, 64'h1111);
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL simple.in_ready got %0b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL simple.read_valid got %0b want 0", out_valid); end
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL simple.valid got %0b want 1", out_valid); end
    vectors++; if (out_rs1_val !== 32'd7 || out_rs2_val !== 32'd0) begin miscompares++; $display("FAIL simple.operands got %h %h want 7 0", out_rs1_val, out_rs2_val); end
    vectors++; if (out_payload !== 64'h1111 || out_rd !== 5'd1) begin miscompares++; $display("FAIL simple.fields got %h %0d want 1111 1", out_payload, out_rd); end
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL simple.after_fire got valid %0b ready %0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_bypass();
    tick();
    drive_in(5'd3, 5'd0, 5'd0, 1'b0, 64'h2222);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA;
    tick(); in_valid = 1'b0; wb_valid = 1'b0;
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bypass.valid got %0b want 1", out_valid); end
    vectors++; if (out_rs1_val !== 32'hAA) begin miscompares++; $display("FAIL bypass.rs1 got %h want 000000aa", out_rs1_val); end
    tick();
  endtask

  task automatic test_raw_stall();
    tick();
    drive_in(5'd0, 5'd0, 5'd4, 1'b1, 64'h3333);
    tick(); in_valid = 1'b0;
    tick();
    drive_in(5'd0, 5'd4, 5'd7, 1'b0, 64'h4444);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL raw.writer got valid %0b ready %0b want 1 1", out_valid, in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dut.u_sb.busy[4] !== 1'b1) begin miscompares++; $display("FAIL raw.busy4 got %0b want 1", dut.u_sb.busy[4]); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL raw.stall%0d got %0b want 0", i, out_valid); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL raw.wb_cycle got %0b want 0", out_valid); end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL raw.release got %0b want 1", out_valid); end
    vectors++; if (out_rs2_val !== 32'h1234 || out_payload !== 64'h4444) begin miscompares++; $display("FAIL raw.rs2 got %h %h want 1234 4444", out_rs2_val, out_payload); end
    vectors++; if (dut.u_sb.busy !== 31'd0) begin miscompares++; $display("FAIL raw.busy got %h want 0", dut.u_sb.busy); end
    tick();
  endtask

  task automatic test_x0();
    tick();
    drive_in(5'd0, 5'd0, 5'd0, 1'b1, 64'h5555);
    tick(); in_valid = 1'b0;
    tick();
    drive_in(5'd0, 5'd0, 5'd2, 1'b0, 64'h6666);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dut.u_sb.busy !== 31'd0) begin miscompares++; $display("FAIL x0.busy got %h want 0", dut.u_sb.busy); end
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1 || out_rs1_val !== 32'd0) begin miscompares++; $display("FAIL x0.issue got valid %0b rs1 %h want 1 0", out_valid, out_rs1_val); end
    tick();
  endtask

  task automatic test_same_cycle();
    tick();
    drive_in(5'd0, 5'd0, 5'd6, 1'b1, 64'h7777);
    tick(); in_valid = 1'b0;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL same.valid got %0b want 1", out_valid); end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dut.u_sb.busy[6] !== 1'b1) begin miscompares++; $display("FAIL same.busy6 got %0b want 1", dut.u_sb.busy[6]); end
  endtask

  task automatic test_backpressure_flush();
    exp_busy = '0; exp_busy[6] = 1'b1;
    out_ready = 1'b0;
    tick();
    drive_in(5'd5, 5'd3, 5'd8, 1'b1, 64'hDEAD_BEEF_0000_0009);
    tick(); in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin miscompares++; $display("FAIL bp.hs%0d got valid %0b ready %0b want 1 0", i, out_valid, in_ready); end
      vectors++; if (out_rs1_val !== 32'd7 || out_rs2_val !== 32'hAA || out_rd !== 5'd8 || out_payload !== 64'hDEAD_BEEF_0000_0009) begin miscompares++; $display("FAIL bp.stable%0d got %h %h %0d %h want 7 aa 8 deadbeef00000009", i, out_rs1_val, out_rs2_val, out_rd, out_payload); end
      tick();
    end
    flush = 1'b1; out_ready = 1'b1;
    drive_in(5'd1, 5'd2, 5'd9, 1'b1, 64'h8888);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL flush.comb got valid %0b ready %0b want 0 0", out_valid, in_ready); end
    tick(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dut.state !== IDLE || in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL flush.idle got state %0d ready %0b want IDLE 1", dut.state, in_ready); end
    vectors++; if (dut.u_sb.busy !== exp_busy) begin miscompares++; $display("FAIL flush.busy got %h want %h", dut.u_sb.busy, exp_busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    tick();
    drive_in(5'd0, 5'd0, 5'd10, 1'b1, 64'h9999);
    tick(); in_valid = 1'b0;
    tick();
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rmid.valid got %0b want 1", out_valid); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || dut.state !== IDLE) begin miscompares++; $display("FAIL rmid.async got valid %0b state %0d want 0 IDLE", out_valid, dut.state); end
    vectors++; if (dut.u_sb.busy !== 31'd0 || out_payload !== 64'd0) begin miscompares++; $display("FAIL rmid.clear got busy %h payload %h want 0 0", dut.u_sb.busy, out_payload); end
    tick(); reset = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
    regs[0] = 32'd0;
    regs[5] = 32'd7;
    test_reset();
    test_simple_issue();
    test_bypass();
    test_raw_stall();
    test_x0();
    test_same_cycle();
    test_backpressure_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
